// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and helpers for the multi-digit LED driver
package led_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}; entry n is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational hex nibble to active-low seven-segment pattern
module hex_to_7seg
    import led_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; all 16 codes are defined.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/multi_digit_led_driver.sv
// rtl/multi_digit_led_driver.sv - time-multiplexed hex LED driver; optional LED_DIMMING_EN
module multi_digit_led_driver
    import led_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] signal_to_display,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
`ifdef LED_DIMMING_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam int IW = cnt_width(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_FIRST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          boundary;

    logic [NUM_DIGITS-1:0][3:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d;
    logic                       pend_flag_q, pend_flag_d;
    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic                  blank;
    logic                  dim_on;
    logic [3:0]            cur_nibble;
    logic [6:0]            dec_seg;

`ifdef LED_DIMMING_EN
    logic [3:0]  brightness_q, brightness_d;
    logic [31:0] rel;
`endif

    // Slot counter and digit index; index walks downward and wraps each frame.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        boundary = (idx_q == '0) && (cnt_q == CNT_LAST);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == '0) ? IDX_FIRST : idx_q - 1'b1;
        end
    end

    // Pending/shadow double buffer; shadow only changes at the frame boundary.
    always_comb begin
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        if (boundary) begin
            if (load) begin
                shadow_d    = signal_to_display;
                shadow_dp_d = dp_mask;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                shadow_d    = pend_q;
                shadow_dp_d = pend_dp_q;
                pend_flag_d = 1'b0;
            end
        end else if (load) begin
            pend_d      = signal_to_display;
            pend_dp_d   = dp_mask;
            pend_flag_d = 1'b1;
        end
    end

    // lz_mask[i] is set when every shadow nibble from i upward is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            zero_run   = zero_run & (shadow_q[j] == 4'h0);
            lz_mask[j] = zero_run;
        end
    end

`ifdef LED_DIMMING_EN
    // Brightness gate: anode on for the first brightness+1 cycles of every 16 after guard.
    always_comb begin
        brightness_d = boundary ? brightness : brightness_q;
        rel          = 32'(cnt_q) - 32'(GUARD_CYCLES);
        dim_on       = ({1'b0, rel[3:0]} < ({1'b0, brightness_q} + 5'd1));
    end
`else
    // Without dimming the anode stays on for the whole non-guard region.
    always_comb begin
        dim_on = 1'b1;
    end
`endif

    assign cur_nibble = shadow_q[idx_q];

    hex_to_7seg u_hex_to_7seg (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Next pin values from the current scan position; registered below.
    always_comb begin
        blank        = blank_lz && (idx_q != '0) && lz_mask[idx_q];
        an_d         = '1;
        seg_d        = blank ? SEG_BLANK : dec_seg;
        dp_d         = blank ? 1'b1 : ~shadow_dp_q[idx_q];
        frame_done_d = boundary;
        if ((cnt_q >= GUARD_END) && dim_on) begin
            an_d[idx_q] = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= IDX_FIRST;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef LED_DIMMING_EN
            brightness_q <= 4'hF;
`endif
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
`ifdef LED_DIMMING_EN
            brightness_q <= brightness_d;
`endif
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_multi_digit_led_driver.sv
// tb/tb_multi_digit_led_driver.sv - directed self-checking bench for multi_digit_led_driver
module tb_multi_digit_led_driver;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int GC = 2;
    localparam int FRAME = ND * CD;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SC = 7'b0110001;
    localparam logic [6:0] SD = 7'b1000010;
    localparam logic [6:0] SE = 7'b0110000;
    localparam logic [6:0] SF = 7'b0111000;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] sig = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int tests_run = 0;
    int tests_failed = 0;
    int e = 0;

    multi_digit_led_driver #(
        .NUM_DIGITS   (ND),
        .CLK_DIV      (CD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .signal_to_display (sig),
        .load              (load),
        .dp_mask           (dp_mask),
        .blank_lz          (blank_lz),
`ifdef LED_DIMMING_EN
        .brightness        (4'hF),
`endif
        .an                (an),
        .seg               (seg),
        .dp                (dp),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) e <= 0;
        else       e <= e + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic goto_edge(input int n);
        int guard = 0;
        while (e < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (e != n) check_eq($sformatf("edge_sync_%0d", n), e, n);
    endtask

    task automatic chk_slot(input int k, input int s, input logic [6:0] es,
                            input logic ed, input string tag);
        int base;
        logic [3:0] ea;
        base = FRAME * k + CD * s;
        ea   = ~(4'b1000 >> s);
        goto_edge(base + 1);
        check_eq($sformatf("%s_guard_an", tag), an, 4'hF);
        check_eq($sformatf("%s_guard_seg", tag), seg, es);
        goto_edge(base + 3);
        check_eq($sformatf("%s_an", tag), an, ea);
        check_eq($sformatf("%s_seg", tag), seg, es);
        check_eq($sformatf("%s_dp", tag), dp, ed);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        sig     = v;
        dp_mask = m;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    initial begin
        #200;
        check_eq("rst_an", an, 4'hF);
        check_eq("rst_seg", seg, SB);
        check_eq("rst_dp", dp, 1'b1);
        check_eq("rst_fd", frame_done, 1'b0);
        #200;
        reset = 1'b0;

        // Frame 0: shadow still zero.
        chk_slot(0, 0, S0, 1'b1, "f0_d3");
        goto_edge(10);
        do_load(16'hA194, 4'h0);
        goto_edge(31);
        check_eq("fd_e31", frame_done, 1'b0);
        goto_edge(32);
        check_eq("fd_e32", frame_done, 1'b1);
        goto_edge(33);
        check_eq("fd_e33", frame_done, 1'b0);

        // Frame 1: A194.
        chk_slot(1, 0, SA, 1'b1, "f1_d3");
        chk_slot(1, 1, S1, 1'b1, "f1_d2");
        chk_slot(1, 2, S9, 1'b1, "f1_d1");
        chk_slot(1, 3, S4, 1'b1, "f1_d0");
        goto_edge(64);
        check_eq("fd_e64", frame_done, 1'b1);

        // Frame 2: two loads mid-frame, last wins, current frame untouched.
        goto_edge(70);
        do_load(16'hCC10, 4'h0);
        goto_edge(72);
        do_load(16'h1234, 4'h0);
        chk_slot(2, 2, S9, 1'b1, "f2_d1");
        chk_slot(2, 3, S4, 1'b1, "f2_d0");
        goto_edge(95);
        check_eq("fd_e95", frame_done, 1'b0);
        goto_edge(96);
        check_eq("fd_e96", frame_done, 1'b1);

        // Frame 3: 1234.
        chk_slot(3, 0, S1, 1'b1, "f3_d3");
        chk_slot(3, 1, S2, 1'b1, "f3_d2");
        chk_slot(3, 2, S3, 1'b1, "f3_d1");
        chk_slot(3, 3, S4, 1'b1, "f3_d0");
        blank_lz = 1'b1;
        do_load(16'h0040, 4'h0);

        // Frame 4: leading-zero blanking of 0040.
        chk_slot(4, 0, SB, 1'b1, "f4_d3");
        chk_slot(4, 1, SB, 1'b1, "f4_d2");
        chk_slot(4, 2, S4, 1'b1, "f4_d1");
        chk_slot(4, 3, S0, 1'b1, "f4_d0");
        do_load(16'h0000, 4'h0);

        // Frame 5: all zero, only digit 0 lit.
        chk_slot(5, 0, SB, 1'b1, "f5_d3");
        chk_slot(5, 2, SB, 1'b1, "f5_d1");
        chk_slot(5, 3, S0, 1'b1, "f5_d0");
        blank_lz = 1'b0;
        do_load(16'h7E2D, 4'b0100);

        // Frame 6: decimal point on digit 2 only.
        chk_slot(6, 0, S7, 1'b1, "f6_d3");
        chk_slot(6, 1, SE, 1'b0, "f6_d2");
        chk_slot(6, 2, S2, 1'b1, "f6_d1");
        chk_slot(6, 3, SD, 1'b1, "f6_d0");

        // Load exactly on the boundary edge goes straight to shadow.
        goto_edge(223);
        do_load(16'hF0C9, 4'h0);
        chk_slot(7, 0, SF, 1'b1, "f7_d3");
        chk_slot(7, 1, S0, 1'b1, "f7_d2");
        chk_slot(7, 2, SC, 1'b1, "f7_d1");
        chk_slot(7, 3, S9, 1'b1, "f7_d0");

        // Asynchronous reset in the middle of the digit-1 slot.
        goto_edge(275);
        check_eq("pre_rst_an", an, 4'b1101);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_an", an, 4'hF);
        check_eq("async_rst_seg", seg, SB);
        check_eq("async_rst_dp", dp, 1'b1);
        check_eq("async_rst_fd", frame_done, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_slot(0, 0, S0, 1'b1, "post_rst_d3");
        chk_slot(0, 3, S0, 1'b1, "post_rst_d0");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
